mvu_stream_arbiter: RTL

Time-shares one matrix-vector unit (MVU) compute instance between N_REQ independent activation streams. The arbiter grants one requester a complete input vector (MW/SIMD beats) at a time and forwards those beats to the MVU input. It records each grant in a tag FIFO and uses the tags to route the corresponding MH/PE output beats back to the originating requester. It sits between the per-layer stream sources/sinks and a single mvu_vvu_axi instance running in MVU mode.

---
 rtl/mvu_arb_pkg.sv | 19 +
 rtl/mvu_arb_tag_fifo.sv | 60 ++++++
 rtl/mvu_stream_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mvu_arb_pkg.sv
// rtl/mvu_arb_pkg.sv - shared state type and beat-count helpers for mvu_stream_arbiter
package mvu_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  // Number of beats needed to move 'total' elements at 'per_beat' elements per beat.
  function automatic int beat_count(input int total, input int per_beat);
    return total / per_beat;
  endfunction

  // Width of a counter covering 0..beats-1, never narrower than one bit.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mvu_arb_tag_fifo.sv
// rtl/mvu_arb_tag_fifo.sv - synchronous FIFO of grant tags with registered occupancy
module mvu_arb_tag_fifo
  import mvu_arb_pkg::*;
#(
  parameter int TAG_W = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [TAG_W-1:0] head
);

  localparam int PW = cnt_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Tag storage; entries outside the pointer window are never read, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_tag;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mvu_stream_arbiter.sv
// rtl/mvu_stream_arbiter.sv - time-shares one MVU between N_REQ streams; MVU_ARB_FIXED_PRIO_EN selects fixed priority
module mvu_stream_arbiter
  import mvu_arb_pkg::*;
#(
  parameter int N_REQ            = 2,
  parameter int MW               = 12,
  parameter int MH               = 4,
  parameter int SIMD             = 6,
  parameter int PE               = 2,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int ACCU_WIDTH       = 24,
  parameter int TAG_DEPTH        = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_REQ-1:0][SIMD*ACTIVATION_WIDTH-1:0]  s_axis_input_tdata,
  input  logic [N_REQ-1:0]                             s_axis_input_tvalid,
  output logic [N_REQ-1:0]                             s_axis_input_tready,
  output logic [SIMD*ACTIVATION_WIDTH-1:0]             m_axis_mvu_input_tdata,
  output logic                                         m_axis_mvu_input_tvalid,
  input  logic                                         m_axis_mvu_input_tready,
  input  logic [PE*ACCU_WIDTH-1:0]                     s_axis_mvu_output_tdata,
  input  logic                                         s_axis_mvu_output_tvalid,
  output logic                                         s_axis_mvu_output_tready,
  output logic [N_REQ-1:0][PE*ACCU_WIDTH-1:0]          m_axis_output_tdata,
  output logic [N_REQ-1:0]                             m_axis_output_tvalid,
  input  logic [N_REQ-1:0]                             m_axis_output_tready
);

  localparam int IN_BEATS  = beat_count(MW, SIMD);
  localparam int OUT_BEATS = beat_count(MH, PE);
  localparam int IN_CW     = cnt_width(IN_BEATS);
  localparam int OUT_CW    = cnt_width(OUT_BEATS);
  localparam int TAG_W     = $clog2(N_REQ);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [TAG_W-1:0]  grant_q;
  logic [TAG_W-1:0]  winner;
  logic [TAG_W-1:0]  search_base;
  logic [TAG_W-1:0]  head;
  logic [IN_CW-1:0]  in_cnt_q;
  logic [OUT_CW-1:0] out_cnt_q;
  logic              any_valid;
  logic              grant_fire;
  logic              in_hs;
  logic              in_last;
  logic              out_hs;
  logic              out_last;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef MVU_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [TAG_W-1:0] rr_ptr_q;

  // Round-robin pointer moves just past the most recent winner.
  always_ff @(posedge clk) begin
    if (rst)             rr_ptr_q <= '0;
    else if (grant_fire) rr_ptr_q <= (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  end

  assign search_base = rr_ptr_q;
`endif

  // Scan requesters from search_base; the smallest offset with tvalid set wins.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(search_base) + k) % N_REQ;
      if (s_axis_input_tvalid[idx]) begin
        winner    = TAG_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

  // A full tag FIFO blocks the grant even if a pop lands in the same cycle.
  assign grant_fire = (state_q == IDLE) && any_valid && !fifo_full;
  assign in_hs      = (state_q == STREAM) && s_axis_input_tvalid[grant_q] && m_axis_mvu_input_tready;
  assign in_last    = in_hs && (in_cnt_q == IN_CW'(IN_BEATS - 1));

  // Input FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Input FSM next state and the forwarding of the granted stream to the MVU.
  always_comb begin
    state_d                 = state_q;
    s_axis_input_tready     = '0;
    m_axis_mvu_input_tvalid = 1'b0;
    m_axis_mvu_input_tdata  = s_axis_input_tdata[grant_q];
    case (state_q)
      IDLE: begin
        if (grant_fire) state_d = STREAM;
      end
      STREAM: begin
        m_axis_mvu_input_tvalid      = s_axis_input_tvalid[grant_q];
        s_axis_input_tready[grant_q] = m_axis_mvu_input_tready;
        if (in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner and count input beats of the vector being forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= '0;
      in_cnt_q <= '0;
    end else if (grant_fire) begin
      grant_q  <= winner;
      in_cnt_q <= '0;
    end else if (in_hs) begin
      in_cnt_q <= in_last ? '0 : in_cnt_q + 1'b1;
    end
  end

  // Route MVU results to the requester whose tag sits at the FIFO head.
  always_comb begin
    m_axis_output_tvalid     = '0;
    s_axis_mvu_output_tready = 1'b0;
    for (int i = 0; i < N_REQ; i++) m_axis_output_tdata[i] = s_axis_mvu_output_tdata;
    if (!fifo_empty) begin
      m_axis_output_tvalid[head] = s_axis_mvu_output_tvalid;
      s_axis_mvu_output_tready   = m_axis_output_tready[head];
    end
  end

  assign out_hs   = !fifo_empty && s_axis_mvu_output_tvalid && m_axis_output_tready[head];
  assign out_last = out_hs && (out_cnt_q == OUT_CW'(OUT_BEATS - 1));

  // Count result beats; the last beat of a vector retires its tag.
  always_ff @(posedge clk) begin
    if (rst)         out_cnt_q <= '0;
    else if (out_hs) out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
  end

  mvu_arb_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant_fire),
    .push_tag (winner),
    .pop      (out_last),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

endmodule
